seq_ctrl: RTL and testbench

SEQ_CTRL -- requirements
Module: seq_ctrl

---
 rtl/seq_ctrl.sv | 148 ++++++++++++++
 tb/tb_seq_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_ctrl.sv
// Request/response sequencer for a sequential multiply/divide engine: one operation in flight.
// Optional watchdog enabled by defining SEQ_CTRL_TIMEOUT_EN (limit set by TimeoutCycles).
module seq_ctrl #(
    parameter int unsigned WidthA        = 32,
    parameter int unsigned WidthB        = 32,
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,

    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [WidthA-1:0]        req_a_i,
    input  logic [WidthB-1:0]        req_b_i,

    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [WidthA+WidthB-1:0] rsp_c_o,
    output logic [WidthA-1:0]        rsp_q_o,
    output logic [WidthB-1:0]        rsp_r_o,
    output logic                     rsp_err_o,

    output logic [WidthA-1:0]        seq_a_o,
    output logic [WidthB-1:0]        seq_b_o,
    output logic                     seq_start_o,
    input  logic [WidthA+WidthB-1:0] seq_c_i,
    input  logic [WidthA-1:0]        seq_q_i,
    input  logic [WidthB-1:0]        seq_r_i,
    input  logic                     seq_finish_i,

    output logic                     busy_o
);

    typedef enum logic [2:0] {StIdle, StStart, StArm, StWait, StResp} state_e;

    state_e state_q;

`ifdef SEQ_CTRL_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
    // Counter value seen in the last ARM/WAIT cycle before the limit is reached.
    localparam logic [CntW-1:0] TmoLast = CntW'(TimeoutCycles - 1);

    logic [CntW-1:0] tmo_cnt_q;
    logic            err_q;

    assign rsp_err_o = err_q;
`else
    logic unused_timeout;

    assign unused_timeout = (TimeoutCycles == 0);
    assign rsp_err_o      = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            seq_start_o <= 1'b0;
            seq_a_o     <= '0;
            seq_b_o     <= '0;
            rsp_valid_o <= 1'b0;
            rsp_c_o     <= '0;
            rsp_q_o     <= '0;
            rsp_r_o     <= '0;
`ifdef SEQ_CTRL_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            seq_start_o <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        seq_a_o     <= req_a_i;
                        seq_b_o     <= req_b_i;
                        seq_start_o <= 1'b1;
                        req_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        state_q     <= StStart;
                    end
                end
                StStart: begin
`ifdef SEQ_CTRL_TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                    state_q <= StArm;
                end
                StArm: begin
                    // A finish still high from the previous operation is ignored here.
`ifdef SEQ_CTRL_TIMEOUT_EN
                    if (tmo_cnt_q == TmoLast) begin
                        rsp_c_o     <= '0;
                        rsp_q_o     <= '0;
                        rsp_r_o     <= '0;
                        err_q       <= 1'b1;
                        rsp_valid_o <= 1'b1;
                        state_q     <= StResp;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                        state_q   <= StWait;
                    end
`else
                    state_q <= StWait;
`endif
                end
                StWait: begin
                    if (seq_finish_i) begin
                        rsp_c_o     <= seq_c_i;
                        rsp_q_o     <= seq_q_i;
                        rsp_r_o     <= seq_r_i;
                        rsp_valid_o <= 1'b1;
`ifdef SEQ_CTRL_TIMEOUT_EN
                        err_q       <= 1'b0;
`endif
                        state_q     <= StResp;
`ifdef SEQ_CTRL_TIMEOUT_EN
                    end else if (tmo_cnt_q == TmoLast) begin
                        rsp_c_o     <= '0;
                        rsp_q_o     <= '0;
                        rsp_r_o     <= '0;
                        err_q       <= 1'b1;
                        rsp_valid_o <= 1'b1;
                        state_q     <= StResp;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
`endif
                    end
                end
                StResp: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        req_ready_o <= 1'b1;
                        busy_o      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    req_ready_o <= 1'b1;
                    busy_o      <= 1'b0;
                    rsp_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_ctrl.sv
// Self-checking bench for seq_ctrl: bench-side engine model, randomized transactions,
// reset and (when SEQ_CTRL_TIMEOUT_EN is defined) watchdog scenarios.
module tb_seq_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_a_i = '0;
    logic [31:0] req_b_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [63:0] rsp_c_o;
    logic [31:0] rsp_q_o;
    logic [31:0] rsp_r_o;
    logic        rsp_err_o;
    logic [31:0] seq_a_o;
    logic [31:0] seq_b_o;
    logic        seq_start_o;
    logic [63:0] seq_c_i = '0;
    logic [31:0] seq_q_i = '0;
    logic [31:0] seq_r_i = '0;
    logic        seq_finish_i = 1'b0;
    logic        busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    seq_ctrl #(
        .WidthA       (32),
        .WidthB       (32),
        .TimeoutCycles(16)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_a_i     (req_a_i),
        .req_b_i     (req_b_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_c_o     (rsp_c_o),
        .rsp_q_o     (rsp_q_o),
        .rsp_r_o     (rsp_r_o),
        .rsp_err_o   (rsp_err_o),
        .seq_a_o     (seq_a_o),
        .seq_b_o     (seq_b_o),
        .seq_start_o (seq_start_o),
        .seq_c_i     (seq_c_i),
        .seq_q_i     (seq_q_i),
        .seq_r_i     (seq_r_i),
        .seq_finish_i(seq_finish_i),
        .busy_o      (busy_o)
    );

    // Engine behaviour: product, quotient, remainder; b=0 yields q=all-ones, r=a.
    function automatic logic [127:0] engine(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] c;
        logic [31:0] q;
        logic [31:0] r;
        c = 64'(a) * 64'(b);
        q = (b != 0) ? a / b : 32'hFFFF_FFFF;
        r = (b != 0) ? a % b : a;
        return {c, q, r};
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of the next idle cycle.
    task automatic run_txn(input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp_c, input logic [31:0] exp_q,
                           input logic [31:0] exp_r, input int fin_dly, input int rdy_dly,
                           input bit stale, input string name);
        logic [127:0] eo;
        int k;
        int starts;
        bit stable_ok;
        bit hold_ok;
        eo = engine(a, b);
        n_tests++;
        if (req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle_ready: got %b want 1", name, req_ready_o);
        end
        req_valid_i = 1'b1;
        req_a_i     = a;
        req_b_i     = b;
        if (stale) begin
            seq_finish_i = 1'b1;
            seq_c_i = {$urandom, $urandom};
            seq_q_i = $urandom;
            seq_r_i = $urandom;
        end
        @(negedge clk_i);
        req_valid_i = 1'b0;
        req_a_i     = $urandom;
        req_b_i     = $urandom;
        k = 0;
        starts = 0;
        stable_ok = 1'b1;
        while (!rsp_valid_o && k < 400) begin
            starts += int'(seq_start_o);
            if (seq_a_o !== a || seq_b_o !== b || req_ready_o !== 1'b0 || busy_o !== 1'b1)
                stable_ok = 1'b0;
            if (k == fin_dly) begin
                seq_finish_i = 1'b1;
                {seq_c_i, seq_q_i, seq_r_i} = eo;
            end else if (!(stale && k <= 1)) begin
                seq_finish_i = 1'b0;
                seq_c_i = {$urandom, $urandom};
                seq_q_i = $urandom;
                seq_r_i = $urandom;
            end
            @(negedge clk_i);
            k++;
        end
        seq_finish_i = 1'b0;
        n_tests++;
        if (starts != 1) begin
            n_fail++;
            $display("FAIL %s start_pulses: got %0d want 1", name, starts);
        end
        n_tests++;
        if (k != fin_dly + 1) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d", name, k, fin_dly + 1);
        end
        n_tests++;
        if (!stable_ok) begin
            n_fail++;
            $display("FAIL %s operands_busy: got unstable want stable", name);
        end
        n_tests++;
        if ({rsp_valid_o, rsp_err_o, rsp_c_o, rsp_q_o, rsp_r_o} !==
            {1'b1, 1'b0, exp_c, exp_q, exp_r}) begin
            n_fail++;
            $display("FAIL %s rsp: got v=%b e=%b c=%h q=%h r=%h want v=1 e=0 c=%h q=%h r=%h",
                     name, rsp_valid_o, rsp_err_o, rsp_c_o, rsp_q_o, rsp_r_o,
                     exp_c, exp_q, exp_r);
        end
        hold_ok = 1'b1;
        for (int i = 0; i < rdy_dly; i++) begin
            seq_finish_i = 1'b1;
            seq_c_i = {$urandom, $urandom};
            @(negedge clk_i);
            if ({rsp_valid_o, rsp_c_o, rsp_q_o, rsp_r_o, req_ready_o} !==
                {1'b1, exp_c, exp_q, exp_r, 1'b0})
                hold_ok = 1'b0;
        end
        seq_finish_i = 1'b0;
        if (rdy_dly > 0) begin
            n_tests++;
            if (!hold_ok) begin
                n_fail++;
                $display("FAIL %s rsp_hold: got changed want stable over %0d cycles",
                         name, rdy_dly);
            end
        end
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        n_tests++;
        if ({rsp_valid_o, req_ready_o, busy_o} !== 3'b010) begin
            n_fail++;
            $display("FAIL %s after_hs: got v/rdy/busy=%b%b%b want 010", name,
                     rsp_valid_o, req_ready_o, busy_o);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        n_tests++;
        if ({busy_o, rsp_valid_o, seq_start_o, seq_a_o, seq_b_o, rsp_c_o, rsp_q_o, rsp_r_o,
             rsp_err_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got nonzero (busy=%b v=%b st=%b) want 0",
                     busy_o, rsp_valid_o, seq_start_o);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
        n_tests++;
        if ({req_ready_o, busy_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_release: got rdy/busy=%b%b want 10", req_ready_o, busy_o);
        end
    endtask

    task automatic test_basic();
        run_txn(32'd7, 32'd3, 64'd21, 32'd2, 32'd1, 4, 0, 1'b0, "basic_7_3");
        run_txn(32'd9, 32'd4, 64'd36, 32'd2, 32'd1, 2, 0, 1'b0, "min_latency");
    endtask

    task automatic test_backpressure();
        run_txn(32'd100, 32'd7, 64'd700, 32'd14, 32'd2, 3, 5, 1'b0, "backpressure");
    endtask

    task automatic test_stale_finish();
        run_txn(32'd50, 32'd6, 64'd300, 32'd8, 32'd2, 5, 0, 1'b1, "stale_finish");
    endtask

    task automatic test_back_to_back();
        run_txn(32'hFFFF_FFFF, 32'd2, 64'h1_FFFF_FFFE, 32'h7FFF_FFFF, 32'd1, 3, 0, 1'b0,
                "b2b_first");
        run_txn(32'd5, 32'd0, 64'd0, 32'hFFFF_FFFF, 32'd5, 2, 0, 1'b0, "b2b_div0");
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] c;
        logic [31:0] q;
        logic [31:0] r;
        int fd;
        for (int n = 0; n < 24; n++) begin
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if ($urandom_range(0, 1) == 1) a = a >> $urandom_range(0, 31);
            c = 64'(a) * 64'(b);
            q = (b == 0) ? 32'hFFFF_FFFF : a / b;
            r = (b == 0) ? a : a % b;
            fd = $urandom_range(2, 9);
            run_txn(a, b, c, q, r, fd, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                    "random");
        end
    endtask

    task automatic test_reset_mid(input bit in_resp, input string name);
        int k;
        bit quiet;
        req_valid_i = 1'b1;
        req_a_i = 32'd12;
        req_b_i = 32'd5;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        k = 0;
        while (k < 3) begin
            seq_finish_i = in_resp && (k == 2);
            @(negedge clk_i);
            k++;
        end
        seq_finish_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        n_tests++;
        if ({busy_o, rsp_valid_o, seq_start_o, seq_a_o, seq_b_o, rsp_c_o, rsp_q_o, rsp_r_o,
             rsp_err_o} !== '0) begin
            n_fail++;
            $display("FAIL %s async_clear: got busy=%b v=%b a=%h want all 0", name,
                     busy_o, rsp_valid_o, seq_a_o);
        end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        n_tests++;
        if ({req_ready_o, busy_o, rsp_valid_o} !== 3'b100) begin
            n_fail++;
            $display("FAIL %s release: got rdy/busy/v=%b%b%b want 100", name,
                     req_ready_o, busy_o, rsp_valid_o);
        end
        quiet = 1'b1;
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            seq_finish_i = 1'b1;
            @(negedge clk_i);
            if (rsp_valid_o !== 1'b0) quiet = 1'b0;
        end
        seq_finish_i = 1'b0;
        rsp_ready_i = 1'b0;
        n_tests++;
        if (!quiet) begin
            n_fail++;
            $display("FAIL %s no_response: got rsp_valid=1 want 0", name);
        end
    endtask

`ifdef SEQ_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        int k;
        req_valid_i = 1'b1;
        req_a_i = 32'd33;
        req_b_i = 32'd3;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        k = 0;
        while (!rsp_valid_o && k < 200) begin
            seq_c_i = {$urandom, $urandom};
            seq_q_i = $urandom;
            @(negedge clk_i);
            k++;
        end
        // ARM is entered one cycle after START, response 16 cycles later.
        n_tests++;
        if (k != 17) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d want 17", k);
        end
        n_tests++;
        if ({rsp_valid_o, rsp_err_o, rsp_c_o, rsp_q_o, rsp_r_o} !== {2'b11, 128'd0}) begin
            n_fail++;
            $display("FAIL timeout_rsp: got v=%b e=%b c=%h q=%h r=%h want v=1 e=1 zeros",
                     rsp_valid_o, rsp_err_o, rsp_c_o, rsp_q_o, rsp_r_o);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        // Finish on the very cycle the limit is hit resolves as a normal completion.
        run_txn(32'd33, 32'd3, 64'd99, 32'd11, 32'd0, 16, 0, 1'b0, "finish_at_limit");
    endtask
`else
    task automatic test_long_wait();
        run_txn(32'd1000, 32'd9, 64'd9000, 32'd111, 32'd1, 60, 1, 1'b0, "long_wait");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_stale_finish();
        test_back_to_back();
        test_random();
        test_reset_mid(1'b0, "reset_in_wait");
        test_reset_mid(1'b1, "reset_in_resp");
`ifdef SEQ_CTRL_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        run_txn(32'd7, 32'd3, 64'd21, 32'd2, 32'd1, 4, 0, 1'b0, "post_reset");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
